// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase multiplexer with a built-in default slave that answers unmapped transfers with ERROR.
// Optional error logger (ERR_ADDR/ERR_VALID/ERR_CNT/ERR_CLR) is enabled by defining AHB_MUX_ERRLOG_EN.
module ahblite_slave_mux #(
  parameter bit Port0_en = 1'b1,
  parameter bit Port1_en = 1'b1,
  parameter bit Port2_en = 1'b1,
  parameter bit Port3_en = 1'b1,
  parameter bit Port4_en = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HADDR,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P4_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P4_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic        P4_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  input  logic [31:0] P4_HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
`ifdef AHB_MUX_ERRLOG_EN
  ,
  input  logic        ERR_CLR,
  output logic [31:0] ERR_ADDR,
  output logic        ERR_VALID,
  output logic [7:0]  ERR_CNT
`endif
);

  localparam logic [4:0] PORT_EN = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};
  localparam logic [5:0] SEL_DEFAULT = 6'b100000;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  // Lowest-index request wins; no request falls through to the default slave.
  function automatic logic [5:0] pick_sel(input logic [4:0] req);
    logic [5:0] s;
    s = SEL_DEFAULT;
    for (int i = 4; i >= 0; i--) begin
      if (req[i]) s = 6'(1) << i;
    end
    return s;
  endfunction

  logic [4:0] hsel_en;
  logic [5:0] sel_d;
  logic [5:0] sel_q;
  logic       unmapped_act;
  ds_state_t  ds_state;
  logic       ds_ready_q;
  logic       ds_resp_q;

  assign hsel_en      = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL} & PORT_EN;
  assign sel_d        = pick_sel(hsel_en);
  assign unmapped_act = sel_d[5] & HTRANS[1];

  // Address phase -> data phase: select register and default-slave FSM
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q      <= SEL_DEFAULT;
      ds_state   <= DS_IDLE;
      ds_ready_q <= 1'b1;
      ds_resp_q  <= 1'b0;
    end else begin
      if (HREADY) sel_q <= sel_d;
      case (ds_state)
        DS_ERR1: begin
          ds_state   <= DS_ERR2;
          ds_ready_q <= 1'b1;
          ds_resp_q  <= 1'b1;
        end
        default: begin
          // Other ports' wait states hold the FSM in place along with sel_q.
          if (HREADY) begin
            if (unmapped_act) begin
              ds_state   <= DS_ERR1;
              ds_ready_q <= 1'b0;
              ds_resp_q  <= 1'b1;
            end else begin
              ds_state   <= DS_IDLE;
              ds_ready_q <= 1'b1;
              ds_resp_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // Data-phase return mux, driven only by the registered select
  always_comb begin
    HREADY = ds_ready_q;
    HRESP  = ds_resp_q;
    HRDATA = 32'h0;
    if (sel_q[0]) begin
      HREADY = P0_HREADYOUT;
      HRESP  = P0_HRESP;
      HRDATA = P0_HRDATA;
    end else if (sel_q[1]) begin
      HREADY = P1_HREADYOUT;
      HRESP  = P1_HRESP;
      HRDATA = P1_HRDATA;
    end else if (sel_q[2]) begin
      HREADY = P2_HREADYOUT;
      HRESP  = P2_HRESP;
      HRDATA = P2_HRDATA;
    end else if (sel_q[3]) begin
      HREADY = P3_HREADYOUT;
      HRESP  = P3_HRESP;
      HRDATA = P3_HRDATA;
    end else if (sel_q[4]) begin
      HREADY = P4_HREADYOUT;
      HRESP  = P4_HRESP;
      HRDATA = P4_HRDATA;
    end
  end

  logic unused_in;

`ifdef AHB_MUX_ERRLOG_EN
  assign unused_in = HTRANS[0];

  // Error log: a capture in the same cycle as ERR_CLR restarts the log at this error.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ERR_ADDR  <= 32'h0;
      ERR_VALID <= 1'b0;
      ERR_CNT   <= 8'h0;
    end else if (HREADY && unmapped_act) begin
      ERR_VALID <= 1'b1;
      if (!ERR_VALID || ERR_CLR) ERR_ADDR <= HADDR;
      if (ERR_CLR)               ERR_CNT  <= 8'd1;
      else if (ERR_CNT != 8'hFF) ERR_CNT  <= ERR_CNT + 8'd1;
    end else if (ERR_CLR) begin
      ERR_ADDR  <= 32'h0;
      ERR_VALID <= 1'b0;
      ERR_CNT   <= 8'h0;
    end
  end
`else
  assign unused_in = ^{HADDR, HTRANS[0]};
`endif

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Self-checking bench for ahblite_slave_mux: directed AHB-Lite scenarios followed by randomized traffic,
// compared against a transfer-level reference model. Error-log checks are active when AHB_MUX_ERRLOG_EN is defined.
module tb_ahblite_slave_mux;

  localparam logic [4:0] EN = 5'b10111;  // port 3 disabled

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = 32'h0;
  logic [4:0]  hsel = 5'b0;
  logic [4:0]  hreadyout = 5'b11111;
  logic [4:0]  hresp = 5'b0;
  logic [31:0] hrdata [5];
  logic        HREADY, HRESP;
  logic [31:0] HRDATA;
`ifdef AHB_MUX_ERRLOG_EN
  logic        err_clr = 1'b0;
  logic [31:0] ERR_ADDR;
  logic        ERR_VALID;
  logic [7:0]  ERR_CNT;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who owns the current data phase, and how far into an ERROR response we are.
  int          m_owner;   // 0..4 = port, 5 = default slave
  int          m_phase;   // 0 = none, 1 = first ERROR cycle, 2 = second ERROR cycle
  logic [31:0] m_err_addr;
  logic        m_err_valid;
  int          m_err_cnt;

  always #5 HCLK = ~HCLK;

  ahblite_slave_mux #(
    .Port0_en(EN[0]), .Port1_en(EN[1]), .Port2_en(EN[2]), .Port3_en(EN[3]), .Port4_en(EN[4])
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(htrans), .HADDR(haddr),
    .P0_HSEL(hsel[0]), .P1_HSEL(hsel[1]), .P2_HSEL(hsel[2]), .P3_HSEL(hsel[3]), .P4_HSEL(hsel[4]),
    .P0_HREADYOUT(hreadyout[0]), .P1_HREADYOUT(hreadyout[1]), .P2_HREADYOUT(hreadyout[2]),
    .P3_HREADYOUT(hreadyout[3]), .P4_HREADYOUT(hreadyout[4]),
    .P0_HRESP(hresp[0]), .P1_HRESP(hresp[1]), .P2_HRESP(hresp[2]), .P3_HRESP(hresp[3]), .P4_HRESP(hresp[4]),
    .P0_HRDATA(hrdata[0]), .P1_HRDATA(hrdata[1]), .P2_HRDATA(hrdata[2]),
    .P3_HRDATA(hrdata[3]), .P4_HRDATA(hrdata[4]),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
`ifdef AHB_MUX_ERRLOG_EN
    , .ERR_CLR(err_clr), .ERR_ADDR(ERR_ADDR), .ERR_VALID(ERR_VALID), .ERR_CNT(ERR_CNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 5;
    m_phase = 0;
    m_err_addr = 32'h0;
    m_err_valid = 1'b0;
    m_err_cnt = 0;
  endtask

  function automatic int pick();
    for (int i = 0; i < 5; i++) if (hsel[i] && EN[i]) return i;
    return 5;
  endfunction

  task automatic expect_out(output logic r, output logic s, output logic [31:0] d);
    if (m_owner < 5) begin
      r = hreadyout[m_owner];
      s = hresp[m_owner];
      d = hrdata[m_owner];
    end else begin
      r = (m_phase != 1);
      s = (m_phase != 0);
      d = 32'h0;
    end
  endtask

  task automatic check_all(input string tag);
    logic r, s;
    logic [31:0] d;
    expect_out(r, s, d);
    chk({tag, ".HREADY"}, {31'b0, HREADY}, {31'b0, r});
    chk({tag, ".HRESP"},  {31'b0, HRESP},  {31'b0, s});
    chk({tag, ".HRDATA"}, HRDATA, d);
`ifdef AHB_MUX_ERRLOG_EN
    chk({tag, ".ERR_ADDR"},  ERR_ADDR, m_err_addr);
    chk({tag, ".ERR_VALID"}, {31'b0, ERR_VALID}, {31'b0, m_err_valid});
    chk({tag, ".ERR_CNT"},   {24'b0, ERR_CNT}, 32'(m_err_cnt));
`endif
  endtask

  // Advance the model across one rising edge using the inputs that were held during the cycle.
  task automatic model_edge();
    logic r, s, cap;
    logic [31:0] d;
    int nxt;
    expect_out(r, s, d);
    nxt = pick();
    cap = (m_phase != 1) && r && (nxt == 5) && htrans[1];
`ifdef AHB_MUX_ERRLOG_EN
    if (cap) begin
      if (!m_err_valid || err_clr) m_err_addr = haddr;
      m_err_cnt = err_clr ? 1 : ((m_err_cnt < 255) ? m_err_cnt + 1 : 255);
      m_err_valid = 1'b1;
    end else if (err_clr) begin
      m_err_addr = 32'h0;
      m_err_valid = 1'b0;
      m_err_cnt = 0;
    end
`endif
    if (m_phase == 1) m_phase = 2;
    else if (r) begin
      m_owner = nxt;
      m_phase = cap ? 1 : 0;
    end
  endtask

  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    @(posedge HCLK);
    model_edge();
    @(negedge HCLK);
  endtask

  task automatic bus_idle();
    htrans = 2'b00;
    hsel = 5'b0;
    hreadyout = 5'b11111;
    hresp = 5'b0;
`ifdef AHB_MUX_ERRLOG_EN
    err_clr = 1'b0;
`endif
  endtask

  initial begin
    for (int i = 0; i < 5; i++) hrdata[i] = 32'h1111_0000 * (i + 1);
    model_reset();
    @(negedge HCLK);
    @(negedge HCLK);
    #1;
    check_all("reset");
    HRESET = 1'b0;
    cycle("idle0");
    cycle("idle1");

    // P0 read
    htrans = 2'b10; hsel = 5'b00001;
    cycle("p0_addr");
    bus_idle(); hrdata[0] = 32'hDEADBEEF;
    cycle("p0_data");

    // P1 with three wait states; P2 address phase held during the stall
    htrans = 2'b10; hsel = 5'b00010;
    cycle("p1_addr");
    hsel = 5'b00100; hreadyout[1] = 1'b0; hrdata[1] = 32'hA5A5_0001;
    cycle("p1_wait0");
    cycle("p1_wait1");
    cycle("p1_wait2");
    hreadyout[1] = 1'b1;
    cycle("p1_done");
    bus_idle(); hrdata[2] = 32'hC0DE_0002; hresp[2] = 1'b1;
    cycle("p2_data");
    bus_idle();
    cycle("idle2");

    // Unmapped active transfer, then unmapped IDLE
    htrans = 2'b10; haddr = 32'h6000_0000;
    cycle("unm_addr");
    bus_idle();
    cycle("unm_err1");
    cycle("unm_err2");
    haddr = 32'h7000_0000; htrans = 2'b11;
    cycle("unm2_addr");
    bus_idle();
    cycle("unm2_err1");
    cycle("unm2_err2");
    htrans = 2'b00;
    cycle("unm_idle_addr");
    cycle("unm_idle_data");

`ifdef AHB_MUX_ERRLOG_EN
    err_clr = 1'b1;
    cycle("errclr");
    err_clr = 1'b0;
    cycle("errclr_after");
`endif

    // Disabled port 3 gets ERROR; P0+P2 routes P0
    htrans = 2'b10; hsel = 5'b01000;
    cycle("p3_addr");
    bus_idle();
    cycle("p3_err1");
    cycle("p3_err2");
    htrans = 2'b10; hsel = 5'b00101;
    cycle("p0p2_addr");
    bus_idle(); hrdata[0] = 32'h0000_0F00; hrdata[2] = 32'h0000_0F02;
    cycle("p0p2_data");

    // Reset asserted during the first ERROR cycle
    htrans = 2'b10; haddr = 32'h8000_0000;
    cycle("mid_addr");
    bus_idle();
    #1;
    check_all("mid_err1");
    HRESET = 1'b1;
    #1;
    model_reset();
    check_all("mid_rst");
    @(negedge HCLK);
    HRESET = 1'b0;
    cycle("mid_after");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      htrans = 2'($urandom_range(3, 0));
      haddr = $urandom;
      case ($urandom_range(3, 0))
        0: hsel = 5'b0;
        1: hsel = 5'(1) << $urandom_range(4, 0);
        default: hsel = 5'($urandom);
      endcase
      for (int i = 0; i < 5; i++) begin
        hreadyout[i] = ($urandom_range(3, 0) != 0);
        hresp[i] = ($urandom_range(7, 0) == 0);
        hrdata[i] = $urandom;
      end
`ifdef AHB_MUX_ERRLOG_EN
      err_clr = ($urandom_range(15, 0) == 0);
`endif
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
